reg_fetch: RTL
==============

Name: reg_fetch

Overview:
Operand-fetch stage sitting directly upstream of the register stack. It accepts decoded instructions over a valid/ready handshake and issues read requests to the register stack. It captures the registered read data one cycle later and forwards in-flight writeback values to resolve read-after-write hazards. It presents operands to the execute stage over a valid/ready handshake.

Parameters:
NIB_SIZE, 4, register-number width (shared include)
WORD_SIZE, 16, data word width (shared include)
OP_SIZE, 4, opcode width passed through untouched (shared include)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous discard of any held or in-flight instruction
in_valid  in  1  decoded instruction available
in_ready  out  1  stage can accept this cycle
in_src1  in  NIB_SIZE  first source register
in_src2  in  NIB_SIZE  second source register
in_dest  in  NIB_SIZE  destination register, passed through
in_op  in  OP_SIZE  opcode, passed through
rs_num1  out  NIB_SIZE  read port 1 register number to the register stack
rs_num2  out  NIB_SIZE  read port 2 register number to the register stack
rs_get_enable  out  1  read strobe to the register stack
rs_out1  in  WORD_SIZE  register stack data 1, valid the cycle after the strobe
rs_out2  in  WORD_SIZE  register stack data 2
wb_enable  in  1  writeback this cycle (same signal as the stack's set_enable)
wb_num  in  NIB_SIZE  writeback register
wb_val  in  WORD_SIZE  writeback value
out_valid  out  1  operands valid
out_ready  in  1  execute stage accepts
out_a  out  WORD_SIZE  operand 1
out_b  out  WORD_SIZE  operand 2
out_dest  out  NIB_SIZE  destination register
out_op  out  OP_SIZE  opcode

Behaviour:
- States: EMPTY, READ, VALID. Reset state is EMPTY.
- Reset values: out_a, out_b, out_dest, out_op = 0; out_valid = 0; in_ready = 0 while rst_n is low.
- Reset is asynchronous and abandons any in-flight read.
- in_ready: 1 in EMPTY, 0 in READ, equal to out_ready in VALID. Forced to 0 when flush = 1.
- Accept occurs when in_valid && in_ready.
  - rs_get_enable = accept, combinational.
  - rs_num1/rs_num2 = in_src1/in_src2 combinational. Hold the last value when not accepting.
  - src, dest and op are latched. Next state is READ.
- Bypass at accept edge:
  - The register stack returns the pre-write value when a write and a read of the same register share an edge.
  - If wb_enable && wb_num == in_src1, latch byp1 = wb_val and set hit1. Same rule for src2.
- READ (exactly one cycle):
  - Operand 1 priority: current-cycle wb hit (wb_enable && wb_num == src1) gives wb_val; else hit1 gives byp1; else rs_out1.
  - Operand 2 follows the same priority.
  - Results are latched into a_q/b_q. Next state is VALID.
- Latency: accept at edge N gives out_valid high from edge N+2.
- VALID:
  - out_valid = 1.
  - out_a = (wb_enable && wb_num == src1) ? wb_val : a_q, combinational forward. out_b uses the same rule.
  - While stalled, every matching writeback updates a_q/b_q.
  - On out_ready: a new accept in the same cycle goes to READ, else EMPTY.
- Both sources equal: both operands receive the same forwarded value.
- flush, any state: next state EMPTY, out_valid drops the next cycle, no accept that cycle. flush overrides out_ready transfer bookkeeping; the execute stage ignores the transfer.
- Register-stack writes are not issued here. Writeback ports are snoop-only.

Optional Feature:
REG_FETCH_BYPASS_EN
- Defined: all forwarding and snooping exactly as above.
- Undefined: no byp regs, no comparators.
  - out_a/out_b = a_q/b_q latched from rs_out1/rs_out2 in READ.
  - Hazards return the stale register-stack value. Software/scheduler must insert spacing.

Decomposition:
- Shared include (existing parameters file): NIB_SIZE, WORD_SIZE, OP_SIZE, REG_STACK_SIZE.
- Add state encodings FETCH_EMPTY=0, FETCH_READ=1, FETCH_VALID=2 there.
- One natural sub-module: fwd_mux. It takes the register number, the writeback triple, the held value and the hit flag, and returns the forwarded word. It is instantiated twice for operands a and b.

Test Plan:
- Reg3=100, reg5=7 preloaded. Issue src1=3, src2=5, op=2, dest=1, out_ready=1 -> out_valid at accept+2, out_a=100, out_b=7, out_op=2, out_dest=1, one cycle.
- Accept src1=4 while wb_enable, wb_num=4, wb_val=55 in the same cycle (stack old 0) -> out_a=55. With the macro undefined, out_a=0.
- wb_num=4, wb_val=66 during READ -> out_a=66. Hold out_ready=0, then write reg4=77 in VALID -> out_a=77 combinationally that cycle and thereafter.
- Back-to-back issue with out_ready=1 on every cycle -> accepts every other cycle. in_ready=0 in READ, no dropped or duplicated instruction.
- flush in READ -> out_valid stays 0, state EMPTY, in_ready=1 the next cycle. flush asserted with in_valid -> rs_get_enable=0.
- rst_n low mid-READ -> out_valid=0, outputs 0 immediately (asynchronous). After release, the first accept behaves as scenario 1.

Source files
------------

// File: rtl/reg_fetch_pkg.sv
// -----------------------------------------------------------------------------
// reg_fetch_pkg
// Shared parameters for the operand-fetch stage and the register stack:
//   NIB_SIZE       register-number width
//   WORD_SIZE      data word width
//   OP_SIZE        opcode width (passed through untouched)
//   REG_STACK_SIZE number of registers in the register stack
// Also holds the fetch-stage state encoding and a writeback-match helper.
// -----------------------------------------------------------------------------
package reg_fetch_pkg;

   localparam int NIB_SIZE       = 4;
   localparam int WORD_SIZE      = 16;
   localparam int OP_SIZE        = 4;
   localparam int REG_STACK_SIZE = 16;

   typedef enum logic [1:0] {
      FETCH_EMPTY = 2'd0,
      FETCH_READ  = 2'd1,
      FETCH_VALID = 2'd2
   } fetch_state_e;

   // True when the writeback in flight this cycle targets register num.
   function automatic logic wb_hit(input logic                en,
                                   input logic [NIB_SIZE-1:0] wb_num,
                                   input logic [NIB_SIZE-1:0] num);
      return en && (wb_num == num);
   endfunction

endpackage

// File: rtl/reg_fetch_fwd_mux.sv
// -----------------------------------------------------------------------------
// reg_fetch_fwd_mux
// Operand forwarding mux. Selects, in priority order:
//   1. the writeback value when this cycle's writeback targets reg_num
//   2. held_val when held_hit is set (earlier captured bypass or held operand)
//   3. stack_val (register stack read data)
// Ports:
//   reg_num                    source register of this operand
//   wb_enable, wb_num, wb_val  snooped writeback triple
//   held_val, held_hit         previously captured value and its valid flag
//   stack_val                  register stack read data
//   fwd_val                    forwarded operand word
// -----------------------------------------------------------------------------
module reg_fetch_fwd_mux
   import reg_fetch_pkg::*;
(
   input  logic [NIB_SIZE-1:0]  reg_num,
   input  logic                 wb_enable,
   input  logic [NIB_SIZE-1:0]  wb_num,
   input  logic [WORD_SIZE-1:0] wb_val,
   input  logic [WORD_SIZE-1:0] held_val,
   input  logic                 held_hit,
   input  logic [WORD_SIZE-1:0] stack_val,
   output logic [WORD_SIZE-1:0] fwd_val
);

   always_comb begin
      fwd_val = stack_val;
      if (wb_hit(wb_enable, wb_num, reg_num)) begin
         fwd_val = wb_val;
      end else if (held_hit) begin
         fwd_val = held_val;
      end
   end

endmodule

// File: rtl/reg_fetch.sv
// -----------------------------------------------------------------------------
// reg_fetch
// Operand-fetch stage in front of the register stack. Accepts decoded
// instructions (valid/ready), strobes a read of both sources into the
// register stack, captures the registered read data one cycle later and
// presents operands to execute (valid/ready). Accept at edge N gives
// out_valid from edge N+2.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      synchronous discard of held/in-flight work
//   in_valid/in_ready          decode-side handshake
//   in_src1/in_src2/in_dest/in_op  decoded instruction fields
//   rs_num1/rs_num2/rs_get_enable  register stack read request
//   rs_out1/rs_out2            register stack data (cycle after strobe)
//   wb_enable/wb_num/wb_val    snooped writeback (never driven from here)
//   out_valid/out_ready        execute-side handshake
//   out_a/out_b/out_dest/out_op    operands and pass-through fields
//
// Configuration macro: REG_FETCH_BYPASS_EN
//   defined   - writeback forwarding at accept, in READ and while stalled
//   undefined - no forwarding; operands are the register stack values read
//               at the accept edge (hazards must be avoided by scheduling)
// -----------------------------------------------------------------------------
module reg_fetch
   import reg_fetch_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NIB_SIZE-1:0]  in_src1,
   input  logic [NIB_SIZE-1:0]  in_src2,
   input  logic [NIB_SIZE-1:0]  in_dest,
   input  logic [OP_SIZE-1:0]   in_op,
   output logic [NIB_SIZE-1:0]  rs_num1,
   output logic [NIB_SIZE-1:0]  rs_num2,
   output logic                 rs_get_enable,
   input  logic [WORD_SIZE-1:0] rs_out1,
   input  logic [WORD_SIZE-1:0] rs_out2,
   input  logic                 wb_enable,
   input  logic [NIB_SIZE-1:0]  wb_num,
   input  logic [WORD_SIZE-1:0] wb_val,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WORD_SIZE-1:0] out_a,
   output logic [WORD_SIZE-1:0] out_b,
   output logic [NIB_SIZE-1:0]  out_dest,
   output logic [OP_SIZE-1:0]   out_op
);

   fetch_state_e         state_q, state_d;
   logic                 accept;
   logic [NIB_SIZE-1:0]  rs_num1_q, rs_num1_d, rs_num2_q, rs_num2_d;
   logic [NIB_SIZE-1:0]  dest_q, dest_d;
   logic [OP_SIZE-1:0]   op_q, op_d;
   logic [WORD_SIZE-1:0] a_q, a_d, b_q, b_d;
   logic [WORD_SIZE-1:0] fwd_a, fwd_b;

   // in_ready is gated by rst_n so it reads 0 for the whole reset window.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         FETCH_EMPTY: in_ready = 1'b1;
         FETCH_VALID: in_ready = out_ready;
         default:     in_ready = 1'b0;
      endcase
      if (flush || !rst_n) begin
         in_ready = 1'b0;
      end
      accept        = in_valid && in_ready;
      rs_get_enable = accept;
   end

   always_comb begin
      state_d   = state_q;
      rs_num1_d = rs_num1_q;
      rs_num2_d = rs_num2_q;
      dest_d    = dest_q;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;

      if (accept) begin
         rs_num1_d = in_src1;
         rs_num2_d = in_src2;
         dest_d    = in_dest;
         op_d      = in_op;
      end

      case (state_q)
         FETCH_EMPTY: begin
            if (accept) state_d = FETCH_READ;
         end
         FETCH_READ: begin
            a_d     = fwd_a;
            b_d     = fwd_b;
            state_d = FETCH_VALID;
         end
         FETCH_VALID: begin
            // Refresh the held operands so stalled writebacks stick.
            a_d = fwd_a;
            b_d = fwd_b;
            if (out_ready) state_d = accept ? FETCH_READ : FETCH_EMPTY;
         end
         default: state_d = FETCH_EMPTY;
      endcase

      if (flush) begin
         state_d = FETCH_EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= FETCH_EMPTY;
         rs_num1_q <= '0;
         rs_num2_q <= '0;
         dest_q    <= '0;
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         state_q   <= state_d;
         rs_num1_q <= rs_num1_d;
         rs_num2_q <= rs_num2_d;
         dest_q    <= dest_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
      end
   end

   assign rs_num1   = rs_num1_d;
   assign rs_num2   = rs_num2_d;
   assign out_valid = (state_q == FETCH_VALID);
   assign out_a     = out_valid ? fwd_a : a_q;
   assign out_b     = out_valid ? fwd_b : b_q;
   assign out_dest  = dest_q;
   assign out_op    = op_q;

`ifdef REG_FETCH_BYPASS_EN
   logic [NIB_SIZE-1:0]  src1_q, src1_d, src2_q, src2_d;
   logic [WORD_SIZE-1:0] byp1_q, byp1_d, byp2_q, byp2_d;
   logic                 hit1_q, hit1_d, hit2_q, hit2_d;

   // The stack returns the pre-write value when a write lands on the accept
   // edge, so that write is captured here and replayed during READ.
   always_comb begin
      src1_d = src1_q;
      src2_d = src2_q;
      byp1_d = byp1_q;
      byp2_d = byp2_q;
      hit1_d = hit1_q;
      hit2_d = hit2_q;
      if (accept) begin
         src1_d = in_src1;
         src2_d = in_src2;
         byp1_d = wb_val;
         byp2_d = wb_val;
         hit1_d = wb_hit(wb_enable, wb_num, in_src1);
         hit2_d = wb_hit(wb_enable, wb_num, in_src2);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         src1_q <= '0;
         src2_q <= '0;
         byp1_q <= '0;
         byp2_q <= '0;
         hit1_q <= 1'b0;
         hit2_q <= 1'b0;
      end else begin
         src1_q <= src1_d;
         src2_q <= src2_d;
         byp1_q <= byp1_d;
         byp2_q <= byp2_d;
         hit1_q <= hit1_d;
         hit2_q <= hit2_d;
      end
   end

   // In READ the held value is the accept-edge bypass; in VALID it is the
   // latched operand, which always takes priority over the stack data.
   reg_fetch_fwd_mux u_fwd_a (
      .reg_num   (src1_q),
      .wb_enable (wb_enable),
      .wb_num    (wb_num),
      .wb_val    (wb_val),
      .held_val  (out_valid ? a_q : byp1_q),
      .held_hit  (out_valid | hit1_q),
      .stack_val (rs_out1),
      .fwd_val   (fwd_a)
   );

   reg_fetch_fwd_mux u_fwd_b (
      .reg_num   (src2_q),
      .wb_enable (wb_enable),
      .wb_num    (wb_num),
      .wb_val    (wb_val),
      .held_val  (out_valid ? b_q : byp2_q),
      .held_hit  (out_valid | hit2_q),
      .stack_val (rs_out2),
      .fwd_val   (fwd_b)
   );
`else
   logic unused_wb;
   assign unused_wb = ^{wb_enable, wb_num, wb_val};

   // Writeback enable tied low: the comparator folds away and the mux only
   // chooses between the stack data (READ) and the held operand (VALID).
   reg_fetch_fwd_mux u_fwd_a (
      .reg_num   ({NIB_SIZE{1'b0}}),
      .wb_enable (1'b0),
      .wb_num    ({NIB_SIZE{1'b0}}),
      .wb_val    ({WORD_SIZE{1'b0}}),
      .held_val  (a_q),
      .held_hit  (out_valid),
      .stack_val (rs_out1),
      .fwd_val   (fwd_a)
   );

   reg_fetch_fwd_mux u_fwd_b (
      .reg_num   ({NIB_SIZE{1'b0}}),
      .wb_enable (1'b0),
      .wb_num    ({NIB_SIZE{1'b0}}),
      .wb_val    ({WORD_SIZE{1'b0}}),
      .held_val  (b_q),
      .held_hit  (out_valid),
      .stack_val (rs_out2),
      .fwd_val   (fwd_b)
   );
`endif

endmodule
